// File: rtl/rf_wb_stage_pkg.sv
// Shared types and constants for the register-file write-back stage.
// Defines the FSM state encoding and the default source-index map.
package rf_wb_stage_pkg;

    typedef enum logic [0:0] {
        WB_IDLE     = 1'b0,
        WB_WAIT_MEM = 1'b1
    } wb_state_t;

    localparam int unsigned WB_SRC_IMM = 32'd0;
    localparam int unsigned WB_SRC_R0  = 32'd1;
    localparam int unsigned WB_SRC_ALU = 32'd2;
    localparam int unsigned WB_SRC_MEM = 32'd3;

    localparam int unsigned WB_NUM_SRC_DEFAULT = 32'd4;

endpackage

// File: rtl/wb_src_sel.sv
// Combinational indexed select from a packed source bus, plus an in-range flag.
// An out-of-range select yields zero data and in_range_o = 0.
module wb_src_sel #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 4,
    parameter int SEL_WIDTH  = 2
) (
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_i,
    input  logic [SEL_WIDTH-1:0]          sel_i,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          in_range_o
);

    // AND-OR mux: at most one source matches, so OR-ing masked slices selects it.
    always_comb begin
        data_o     = {DATA_WIDTH{1'b0}};
        in_range_o = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            data_o     = data_o | ({DATA_WIDTH{sel_i == SEL_WIDTH'(i)}}
                                   & src_data_i[i*DATA_WIDTH +: DATA_WIDTH]);
            in_range_o = in_range_o | (sel_i == SEL_WIDTH'(i));
        end
    end

endmodule

// File: rtl/rf_wb_stage.sv
// Register-file write-back stage: selects a source, registers data/address and
// issues a one-cycle write strobe, waiting in WB_WAIT_MEM for late memory data.
module rf_wb_stage
    import rf_wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_SRC     = 4,
    parameter int RADDR_WIDTH = 2,
    parameter int MEM_SRC_IDX = WB_SRC_MEM
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     flush,
    input  logic                                     req_valid,
    output logic                                     req_ready,
    input  logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] req_src,
    input  logic [RADDR_WIDTH-1:0]                   req_rd,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]            src_data,
    input  logic                                     mem_valid,
    output logic                                     rf_we,
    output logic [RADDR_WIDTH-1:0]                   rf_waddr,
    output logic [DATA_WIDTH-1:0]                    rf_wdata,
    output logic                                     illegal_src,
    output logic                                     busy
);

    localparam int SEL_WIDTH = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    wb_state_t               state_q, state_d;
    logic                    rf_we_q, rf_we_d;
    logic [RADDR_WIDTH-1:0]  rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
    logic                    illegal_q, illegal_d;
    logic [RADDR_WIDTH-1:0]  pend_rd_q, pend_rd_d;

    logic [DATA_WIDTH-1:0]   sel_data_s;
    logic                    sel_in_range_s;
    logic [DATA_WIDTH-1:0]   mem_data_s;
    logic                    accept_s;
    logic                    is_mem_src_s;

    wb_src_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SRC    (NUM_SRC),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_src_sel (
        .src_data_i (src_data),
        .sel_i      (req_src),
        .data_o     (sel_data_s),
        .in_range_o (sel_in_range_s)
    );

    // The memory slot is read directly: in WB_WAIT_MEM req_src no longer names it.
    assign mem_data_s   = src_data[MEM_SRC_IDX*DATA_WIDTH +: DATA_WIDTH];
    assign is_mem_src_s = (req_src == SEL_WIDTH'(MEM_SRC_IDX));
    assign req_ready    = (state_q == WB_IDLE);
    assign accept_s     = req_valid & req_ready;

    // Next-state, capture and strobe decode; flush overrides everything else.
    always_comb begin
        state_d    = state_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        illegal_d  = 1'b0;
        pend_rd_d  = pend_rd_q;
        case (state_q)
            WB_IDLE: begin
                if (flush) begin
                    state_d = WB_IDLE;
                end else if (accept_s) begin
                    if (!sel_in_range_s) begin
                        illegal_d = 1'b1;
                    end else if (is_mem_src_s && !mem_valid) begin
                        pend_rd_d = req_rd;
                        state_d   = WB_WAIT_MEM;
                    end else begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = req_rd;
                        rf_wdata_d = sel_data_s;
                    end
                end else begin
                    state_d = WB_IDLE;
                end
            end
            WB_WAIT_MEM: begin
                if (flush) begin
                    state_d = WB_IDLE;
                end else if (mem_valid) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = pend_rd_q;
                    rf_wdata_d = mem_data_s;
                    state_d    = WB_IDLE;
                end else begin
                    state_d = WB_WAIT_MEM;
                end
            end
            default: begin
                state_d = WB_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WB_IDLE;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= {RADDR_WIDTH{1'b0}};
            rf_wdata_q <= {DATA_WIDTH{1'b0}};
            illegal_q  <= 1'b0;
            pend_rd_q  <= {RADDR_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            illegal_q  <= illegal_d;
            pend_rd_q  <= pend_rd_d;
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign illegal_src = illegal_q;
    assign busy        = (state_q == WB_WAIT_MEM);

endmodule

// File: tb/tb_rf_wb_stage.sv
// Bench for rf_wb_stage: default 8-bit/4-source instance plus a 16-bit/6-source
// instance, each checked every cycle against a rule-level model and by literals.
module tb_rf_wb_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- instance A: defaults (8b, 4 sources, mem idx 3)
    logic        a_flush = 1'b0, a_req_valid = 1'b0, a_mem_valid = 1'b0;
    logic        a_req_ready, a_rf_we, a_illegal, a_busy;
    logic [1:0]  a_req_src = 2'd0, a_req_rd = 2'd0, a_rf_waddr;
    logic [31:0] a_src = 32'd0;
    logic [7:0]  a_rf_wdata;

    rf_wb_stage u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .req_valid(a_req_valid),
        .req_ready(a_req_ready), .req_src(a_req_src), .req_rd(a_req_rd),
        .src_data(a_src), .mem_valid(a_mem_valid), .rf_we(a_rf_we),
        .rf_waddr(a_rf_waddr), .rf_wdata(a_rf_wdata), .illegal_src(a_illegal),
        .busy(a_busy)
    );

    // ---------------- instance B: 16b, 6 sources, mem idx 5, 3-bit rd
    logic        b_flush = 1'b0, b_req_valid = 1'b0, b_mem_valid = 1'b0;
    logic        b_req_ready, b_rf_we, b_illegal, b_busy;
    logic [2:0]  b_req_src = 3'd0, b_req_rd = 3'd0, b_rf_waddr;
    logic [95:0] b_src = 96'd0;
    logic [15:0] b_rf_wdata;

    rf_wb_stage #(.DATA_WIDTH(16), .NUM_SRC(6), .RADDR_WIDTH(3), .MEM_SRC_IDX(5)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .req_valid(b_req_valid),
        .req_ready(b_req_ready), .req_src(b_req_src), .req_rd(b_req_rd),
        .src_data(b_src), .mem_valid(b_mem_valid), .rf_we(b_rf_we),
        .rf_waddr(b_rf_waddr), .rf_wdata(b_rf_wdata), .illegal_src(b_illegal),
        .busy(b_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- rule-level models: a pending memory rd or nothing, plus last write
    logic       ma_wait, ma_we, ma_ill;
    logic [1:0] ma_rd, ma_addr;
    logic [7:0] ma_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_wait <= 1'b0; ma_we <= 1'b0; ma_ill <= 1'b0;
            ma_rd <= 2'd0; ma_addr <= 2'd0; ma_data <= 8'd0;
        end else begin
            ma_we  <= 1'b0;
            ma_ill <= 1'b0;
            if (a_flush) begin
                ma_wait <= 1'b0;
            end else if (ma_wait) begin
                if (a_mem_valid) begin
                    ma_we <= 1'b1; ma_addr <= ma_rd; ma_data <= a_src[24 +: 8]; ma_wait <= 1'b0;
                end
            end else if (a_req_valid) begin
                if (int'(a_req_src) >= 4) ma_ill <= 1'b1;
                else if (int'(a_req_src) == 3 && !a_mem_valid) begin
                    ma_wait <= 1'b1; ma_rd <= a_req_rd;
                end else begin
                    ma_we <= 1'b1; ma_addr <= a_req_rd; ma_data <= a_src[int'(a_req_src)*8 +: 8];
                end
            end
        end
    end

    logic        mb_wait, mb_we, mb_ill;
    logic [2:0]  mb_rd, mb_addr;
    logic [15:0] mb_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mb_wait <= 1'b0; mb_we <= 1'b0; mb_ill <= 1'b0;
            mb_rd <= 3'd0; mb_addr <= 3'd0; mb_data <= 16'd0;
        end else begin
            mb_we  <= 1'b0;
            mb_ill <= 1'b0;
            if (b_flush) begin
                mb_wait <= 1'b0;
            end else if (mb_wait) begin
                if (b_mem_valid) begin
                    mb_we <= 1'b1; mb_addr <= mb_rd; mb_data <= b_src[80 +: 16]; mb_wait <= 1'b0;
                end
            end else if (b_req_valid) begin
                if (int'(b_req_src) >= 6) mb_ill <= 1'b1;
                else if (int'(b_req_src) == 5 && !b_mem_valid) begin
                    mb_wait <= 1'b1; mb_rd <= b_req_rd;
                end else begin
                    mb_we <= 1'b1; mb_addr <= b_req_rd; mb_data <= b_src[int'(b_req_src)*16 +: 16];
                end
            end
        end
    end

    // Per-cycle comparison of both instances against their models.
    always @(negedge clk) begin
        check("a_we_model",    32'(a_rf_we),     32'(ma_we));
        check("a_waddr_model", 32'(a_rf_waddr),  32'(ma_addr));
        check("a_wdata_model", 32'(a_rf_wdata),  32'(ma_data));
        check("a_ill_model",   32'(a_illegal),   32'(ma_ill));
        check("a_busy_model",  32'(a_busy),      32'(ma_wait));
        check("a_ready_model", 32'(a_req_ready), 32'(!ma_wait));
        check("b_we_model",    32'(b_rf_we),     32'(mb_we));
        check("b_waddr_model", 32'(b_rf_waddr),  32'(mb_addr));
        check("b_wdata_model", 32'(b_rf_wdata),  32'(mb_data));
        check("b_ill_model",   32'(b_illegal),   32'(mb_ill));
        check("b_busy_model",  32'(b_busy),      32'(mb_wait));
        check("b_ready_model", 32'(b_req_ready), 32'(!mb_wait));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 6; i++) b_src[i*16 +: 16] = 16'hB000 + 16'(i);
        tick(); tick();
        check("rst_we",    32'(a_rf_we),     32'd0);
        check("rst_waddr", 32'(a_rf_waddr),  32'd0);
        check("rst_wdata", 32'(a_rf_wdata),  32'd0);
        check("rst_ill",   32'(a_illegal),   32'd0);
        check("rst_busy",  32'(a_busy),      32'd0);
        check("rst_ready", 32'(a_req_ready), 32'd1);
        rst_n = 1'b1;

        // ALU source, latency 1, single pulse, data held afterwards
        tick();
        a_src = 32'h00A50000; a_req_valid = 1'b1; a_req_src = 2'd2; a_req_rd = 2'd1;
        tick();
        check("alu_we", 32'(a_rf_we), 32'd1);
        check("alu_waddr", 32'(a_rf_waddr), 32'd1);
        check("alu_wdata", 32'(a_rf_wdata), 32'hA5);
        a_req_valid = 1'b0;
        tick();
        check("alu_we_drop", 32'(a_rf_we), 32'd0);
        check("alu_hold_wdata", 32'(a_rf_wdata), 32'hA5);

        // asynchronous reset mid-run clears outputs immediately
        #2 rst_n = 1'b0;
        #1;
        check("midrst_waddr", 32'(a_rf_waddr), 32'd0);
        check("midrst_wdata", 32'(a_rf_wdata), 32'd0);
        check("midrst_ready", 32'(a_req_ready), 32'd1);
        tick(); rst_n = 1'b1;

        // memory source arriving late
        a_req_valid = 1'b1; a_req_src = 2'd3; a_req_rd = 2'd2; a_mem_valid = 1'b0;
        tick();
        check("mw_busy0", 32'(a_busy), 32'd1);
        check("mw_ready0", 32'(a_req_ready), 32'd0);
        a_req_valid = 1'b0;
        tick(); check("mw_busy1", 32'(a_busy), 32'd1);
        tick(); check("mw_busy2", 32'(a_busy), 32'd1);
        a_src = 32'h3C000000; a_mem_valid = 1'b1;
        tick();
        check("mw_we", 32'(a_rf_we), 32'd1);
        check("mw_waddr", 32'(a_rf_waddr), 32'd2);
        check("mw_wdata", 32'(a_rf_wdata), 32'h3C);
        check("mw_ready", 32'(a_req_ready), 32'd1);
        a_mem_valid = 1'b0;
        tick(); check("mw_we_drop", 32'(a_rf_we), 32'd0);

        // memory source already valid: no wait
        a_src = 32'h5A000000; a_req_valid = 1'b1; a_req_src = 2'd3; a_req_rd = 2'd3; a_mem_valid = 1'b1;
        tick();
        check("md_we", 32'(a_rf_we), 32'd1);
        check("md_wdata", 32'(a_rf_wdata), 32'h5A);
        check("md_busy", 32'(a_busy), 32'd0);
        a_req_valid = 1'b0; a_mem_valid = 1'b0;

        // back-to-back writes
        a_src = 32'h00002211; a_req_valid = 1'b1; a_req_src = 2'd0; a_req_rd = 2'd0;
        tick();
        check("b2b1_we", 32'(a_rf_we), 32'd1);
        check("b2b1_waddr", 32'(a_rf_waddr), 32'd0);
        check("b2b1_wdata", 32'(a_rf_wdata), 32'h11);
        a_req_src = 2'd1; a_req_rd = 2'd3;
        tick();
        check("b2b2_we", 32'(a_rf_we), 32'd1);
        check("b2b2_waddr", 32'(a_rf_waddr), 32'd3);
        check("b2b2_wdata", 32'(a_rf_wdata), 32'h22);
        a_req_valid = 1'b0;
        tick(); check("b2b_we_drop", 32'(a_rf_we), 32'd0);

        // flush beats mem_valid; later mem_valid in IDLE ignored
        a_req_valid = 1'b1; a_req_src = 2'd3; a_req_rd = 2'd1; a_mem_valid = 1'b0;
        tick(); check("fl_busy", 32'(a_busy), 32'd1);
        a_req_valid = 1'b0; a_flush = 1'b1; a_mem_valid = 1'b1;
        tick();
        check("fl_we", 32'(a_rf_we), 32'd0);
        check("fl_busy_clr", 32'(a_busy), 32'd0);
        check("fl_ready", 32'(a_req_ready), 32'd1);
        a_flush = 1'b0;
        tick(); check("fl_idle_mem_ign", 32'(a_rf_we), 32'd0);
        a_mem_valid = 1'b0;

        // flush in IDLE discards the request even though req_ready reads 1
        a_flush = 1'b1; a_req_valid = 1'b1; a_req_src = 2'd2; a_req_rd = 2'd1;
        #1 check("fli_ready", 32'(a_req_ready), 32'd1);
        tick(); check("fli_we", 32'(a_rf_we), 32'd0);
        a_flush = 1'b0; a_req_valid = 1'b0;

        // reset while waiting loses the pending write
        a_req_valid = 1'b1; a_req_src = 2'd3; a_req_rd = 2'd2;
        tick(); check("rw_busy", 32'(a_busy), 32'd1);
        a_req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("rw_busy_clr", 32'(a_busy), 32'd0);
        tick(); rst_n = 1'b1; a_mem_valid = 1'b1;
        tick(); check("rw_no_we", 32'(a_rf_we), 32'd0);
        a_mem_valid = 1'b0;

        // accept during an rf_we cycle straight into a memory wait
        a_src = 32'hC3007700; a_req_valid = 1'b1; a_req_src = 2'd1; a_req_rd = 2'd1;
        tick(); check("bw_we", 32'(a_rf_we), 32'd1);
        a_req_src = 2'd3; a_req_rd = 2'd0;
        tick(); check("bw_busy", 32'(a_busy), 32'd1);
        a_req_valid = 1'b0; a_mem_valid = 1'b1;
        tick();
        check("bw_waddr", 32'(a_rf_waddr), 32'd0);
        check("bw_wdata", 32'(a_rf_wdata), 32'hC3);
        a_mem_valid = 1'b0;

        // instance B: illegal sources 6 and 7, then a normal write
        b_req_valid = 1'b1; b_req_src = 3'd6; b_req_rd = 3'd5;
        tick();
        check("ill6_flag", 32'(b_illegal), 32'd1);
        check("ill6_we", 32'(b_rf_we), 32'd0);
        b_req_src = 3'd7;
        tick(); check("ill7_flag", 32'(b_illegal), 32'd1);
        b_req_src = 3'd4;
        tick();
        check("bok_ill", 32'(b_illegal), 32'd0);
        check("bok_waddr", 32'(b_rf_waddr), 32'd5);
        check("bok_wdata", 32'(b_rf_wdata), 32'hB004);
        b_req_valid = 1'b0;
        tick(); check("bok_we_drop", 32'(b_rf_we), 32'd0);

        // instance B: memory source wait
        b_req_valid = 1'b1; b_req_src = 3'd5; b_req_rd = 3'd6;
        tick(); check("bm_busy", 32'(b_busy), 32'd1);
        b_req_valid = 1'b0; b_mem_valid = 1'b1;
        tick();
        check("bm_waddr", 32'(b_rf_waddr), 32'd6);
        check("bm_wdata", 32'(b_rf_wdata), 32'hB005);
        b_mem_valid = 1'b0;
        tick(); check("bm_we_drop", 32'(b_rf_we), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
